// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shifter.
// SHIFT_ROTATE_EN enables the ROL/ROR wrap path; without it ops 3/4 are illegal.
package shift_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    function automatic logic is_legal_op(logic [OP_W-1:0] op);
`ifdef SHIFT_ROTATE_EN
        return op <= ROR;
`else
        return op <= SRA;
`endif
    endfunction

    // Left ops run through the right-shifting core on a bit-reversed operand.
    function automatic logic is_left_op(logic [OP_W-1:0] op);
        return (op == SLL) || (op == ROL);
    endfunction

endpackage

// File: rtl/shift_layer.sv
// One logarithmic layer: shifts right by DIST when enabled, filling per op.
// SHIFT_ROTATE_EN adds the rotate wrap-around fill.
module shift_layer
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIST   = 1
) (
    input  logic [DATA_W-1:0] din,
    input  logic              en,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] dout
);

    logic [DIST-1:0] fill;

    always_comb begin
        fill = '0;
        if (op == SRA) begin
            // The MSB stays the sign bit through every arithmetic layer.
            fill = {DIST{din[DATA_W-1]}};
        end
`ifdef SHIFT_ROTATE_EN
        else if (op == ROL || op == ROR) begin
            fill = din[DIST-1:0];
        end
`endif
        dout = en ? {fill, din[DATA_W-1:DIST]} : din;
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined multi-mode shifter (SLL/SRL/SRA, plus ROL/ROR under SHIFT_ROTATE_EN)
// with STAGES register stages, a global-stall valid/ready handshake and flush.
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int STAGES  = 2,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [OP_W-1:0]    op_i,
    input  logic [DATA_W-1:0]  a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  s_o,
    output logic               illegal_o
);

    localparam int LAST = STAGES - 1;

    logic                              adv;
    logic [STAGES:0]                   vld_pipe;
    logic [DATA_W-1:0]                 a_rev;
    logic [DATA_W-1:0]                 res_rev;
    logic [DATA_W-1:0]                 entry;

    logic [STAGES-1:0][DATA_W-1:0]     st_data;
    logic [STAGES-1:0][DATA_W-1:0]     nxt_data;
    logic [STAGES-1:0][SHAMT_W-1:0]    st_shamt;
    logic [STAGES-1:0][OP_W-1:0]       st_op;
    logic [STAGES-1:0]                 st_ill;

    logic [SHAMT_W-1:0][DATA_W-1:0]    lin;
    logic [SHAMT_W-1:0][DATA_W-1:0]    lout;
    logic [SHAMT_W-1:0]                len;
    logic [SHAMT_W-1:0][OP_W-1:0]      lop;

    assign adv         = !flush_i && (!out_valid_o || out_ready_i);
    assign in_ready_o  = adv;
    assign vld_pipe[0] = in_valid_i;
    assign out_valid_o = vld_pipe[STAGES];

    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            a_rev[i]   = a_i[DATA_W-1-i];
            res_rev[i] = st_data[LAST][DATA_W-1-i];
        end
    end

    // Illegal ops enter as zero so they emerge as zero without extra output muxing.
    assign entry = !is_legal_op(op_i) ? '0 : (is_left_op(op_i) ? a_rev : a_i);

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_layer
        localparam int S  = (k * STAGES) / SHAMT_W;
        localparam int SN = ((k + 1) * STAGES) / SHAMT_W;

        if (S == 0) begin : g_ctl0
            assign len[k] = shamt_i[k];
            assign lop[k] = op_i;
        end else begin : g_ctlr
            assign len[k] = st_shamt[S-1][k];
            assign lop[k] = st_op[S-1];
        end

        if (k == 0) begin : g_in0
            assign lin[k] = entry;
        end else if ((((k - 1) * STAGES) / SHAMT_W) != S) begin : g_inreg
            assign lin[k] = st_data[S-1];
        end else begin : g_inchain
            assign lin[k] = lout[k-1];
        end

        shift_layer #(
            .DATA_W (DATA_W),
            .DIST   (1 << k)
        ) u_layer (
            .din  (lin[k]),
            .en   (len[k]),
            .op   (lop[k]),
            .dout (lout[k])
        );

        if (k == SHAMT_W - 1 || SN != S) begin : g_out
            assign nxt_data[S] = lout[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe[STAGES:1] <= '0;
            st_data            <= '0;
            st_shamt           <= '0;
            st_op              <= '0;
            st_ill             <= '0;
        end else if (flush_i) begin
            vld_pipe[STAGES:1] <= '0;
        end else if (adv) begin
            vld_pipe[1] <= vld_pipe[0];
            st_data[0]  <= nxt_data[0];
            st_shamt[0] <= shamt_i;
            st_op[0]    <= op_i;
            st_ill[0]   <= !is_legal_op(op_i);
            for (int s = 1; s < STAGES; s++) begin
                vld_pipe[s+1] <= vld_pipe[s];
                st_data[s]    <= nxt_data[s];
                st_shamt[s]   <= st_shamt[s-1];
                st_op[s]      <= st_op[s-1];
                st_ill[s]     <= st_ill[s-1];
            end
        end
    end

    // Output undoes the entry reversal; it is a pure function of the last register,
    // so it holds steady across a stall.
    assign s_o       = is_left_op(st_op[LAST]) ? res_rev : st_data[LAST];
    assign illegal_o = st_ill[LAST];

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined multi-mode shifter for the execute stage. It generalises the fixed 32-bit logical-left shifter to:
- any power-of-two width;
- five shift/rotate operations;
- a configurable number of register stages, with a valid/ready handshake and a flush input.

It sits between the ALU operand mux and the writeback result mux. It lets shift operations meet timing at wide widths without stalling unrelated ALU ops.

## Interface
- DATA_W, 32, operand width; power of two, 8..64
- SHAMT_W, $clog2(DATA_W), shift-amount width (derived, do not override)
- STAGES, 2, register stages; 1..SHAMT_W
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block accepts input this cycle
- op_i  in  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; 5..7 illegal
- a_i  in  DATA_W  operand
- shamt_i  in  SHAMT_W  shift amount
- flush_i  in  1  synchronous kill of all in-flight beats
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts result
- s_o  out  DATA_W  result
- illegal_o  out  1  qualified by out_valid_o; op was illegal, s_o is 0

## Operation
- Logarithmic shifter: SHAMT_W layers, layer k shifts by 2^k when shamt bit k is set.
- Left operations bit-reverse the operand on entry and the result on exit; the core always shifts right.
- Fill bit per layer:
  - 0 for SLL/SRL;
  - a_i[DATA_W-1] for SRA;
  - the wrapped bits for ROL/ROR.
- shamt = 0 gives s_o = a_i for every legal op.
- No shift amount is out of range; width is exactly SHAMT_W.
- Layer k belongs to pipeline stage floor(k*STAGES/SHAMT_W).
- Each stage ends in a register holding:
  - valid;
  - partial data;
  - the remaining shamt bits;
  - op;
  - illegal flag.
- Handshake:
  - in_ready_o = !flush_i && (!out_valid_o || out_ready_i).
  - The whole pipe advances when that condition holds (global stall); otherwise all stages hold.
  - A beat is accepted when in_valid_i && in_ready_o.
  - A result is consumed when out_valid_o && out_ready_i.
  - A stall never drops, duplicates or reorders beats.
- flush_i clears every stage valid bit at the next edge.
  - A flush in the same cycle as in_valid_i does not accept the input, because ready is low.
  - A flush in the same cycle as out_ready_i still clears the output; the consumer treats that beat as killed.
- An illegal op (5..7) travels the pipe normally and emerges with s_o = 0 and illegal_o = 1.

## Timing
- Latency is exactly STAGES cycles from acceptance to out_valid_o, absent stalls.
- Throughput is 1 beat/cycle when out_ready_i is held high.
- Asynchronous reset values:
  - all valid bits 0;
  - all data, shamt and op registers 0;
  - out_valid_o 0, s_o 0, illegal_o 0;
  - in_ready_o 1 once rst_ni is high and flush_i is low.
- Reset asserted mid-operation discards all in-flight beats immediately, with no output.
- s_o and illegal_o are held stable while out_valid_o is high and out_ready_i is low.

## Configuration
- SHIFT_ROTATE_EN:
  - Defined: ROL/ROR are implemented as above.
  - Undefined: the rotate wrap path is not synthesised, and ops 3 and 4 are treated as illegal (s_o = 0, illegal_o = 1). SLL/SRL/SRA are unchanged.

## Structure
- Package shift_pkg:
  - shift_op_e enum (SLL, SRL, SRA, ROL, ROR);
  - OP_W = 3;
  - function is_legal_op(op), aware of SHIFT_ROTATE_EN.
- Sub-module shift_layer holds one log layer:
  - parameters DATA_W and DIST;
  - inputs data, enable, op;
  - output data, with fill selection.
- The top instantiates SHAMT_W layers via generate and inserts stage registers per the mapping rule.

## Test plan
- DATA_W=32, STAGES=2. SLL a=0x0000_0001, shamt=31 → s_o=0x8000_0000 exactly 2 cycles after acceptance. SRL a=0xFFFF_FFFF, shamt=0 → 0xFFFF_FFFF.
- SRA a=0x8000_0000, shamt=4 → 0xF800_0000. SRA a=0x7000_0000, shamt=4 → 0x0700_0000.
- Rotates with SHIFT_ROTATE_EN defined: ROR a=0x0000_00F1, shamt=4 → 0x1000_000F. ROL a=0x8000_0001, shamt=1 → 0x0000_0003.
- Illegal ops: op=6 → illegal_o=1, s_o=0. Without SHIFT_ROTATE_EN, ROR → illegal_o=1, s_o=0.
- Stall: 4 back-to-back beats with out_ready_i low for 3 cycles.
  - in_ready_o drops once the pipe is full.
  - All 4 results emerge in order with correct values.
  - s_o stays stable while stalled.
- Kill paths:
  - flush_i for one cycle with 2 beats in flight: out_valid_o stays 0 afterwards, and a beat presented during the flush is not accepted.
  - rst_ni low mid-stream: out_valid_o drops immediately, and no stale result appears after release.
